// File: rtl/oldland_regbank.sv
// Register bank for the oldland pipeline: storage, registered read selects, multi-stage operand
// forwarding and a per-register outstanding-load scoreboard that drives the execute stall.
module oldland_regbank #(
    parameter int unsigned  DATA_WIDTH     = 32,
    parameter int unsigned  NUM_REGS       = 8,
    parameter int unsigned  NUM_READ_PORTS = 2,
    parameter int unsigned  NUM_FWD_STAGES = 2,
    parameter int unsigned  PEND_W         = 2,
    parameter bit           ZERO_REG       = 1'b0,
    localparam int unsigned SEL_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_READ_PORTS*SEL_W-1:0]      rs_sel,
    input  logic                                 hold,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rs_data,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_valid,
    input  logic [NUM_FWD_STAGES*SEL_W-1:0]      fwd_sel,
    input  logic [NUM_FWD_STAGES*DATA_WIDTH-1:0] fwd_val,
    input  logic                                 wr_en,
    input  logic [SEL_W-1:0]                     wr_sel,
    input  logic [DATA_WIDTH-1:0]                wr_val,
    input  logic                                 wr_is_load,
    input  logic                                 claim_en,
    input  logic [SEL_W-1:0]                     claim_sel,
    output logic                                 load_stall,
    output logic                                 sb_overflow
);
    localparam logic [PEND_W-1:0] PendMax = '1;

    logic [DATA_WIDTH-1:0] regs_q    [NUM_REGS];
    logic [SEL_W-1:0]      e_sel_q   [NUM_READ_PORTS];
    logic [PEND_W-1:0]     pend_q    [NUM_REGS];
    logic [PEND_W-1:0]     pend_d    [NUM_REGS];
    logic                  overflow_q, overflow_d;
    logic [NUM_REGS-1:0]   claim_hit, load_hit;
    logic [NUM_READ_PORTS-1:0] port_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (wr_en) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (wr_sel == SEL_W'(r) && !(ZERO_REG && r == 0)) regs_q[r] <= wr_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned p = 0; p < NUM_READ_PORTS; p++) e_sel_q[p] <= '0;
        end else if (!hold) begin
            for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
                e_sel_q[p] <= rs_sel[p*SEL_W +: SEL_W];
            end
        end
    end

    // Register 0 is never tracked when it is hardwired to zero.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_hit
        localparam bit Tracked = !(ZERO_REG && r == 0);
        assign claim_hit[r] = Tracked && claim_en && (claim_sel == SEL_W'(r));
        assign load_hit[r]  = Tracked && wr_en && wr_is_load && (wr_sel == SEL_W'(r));
    end

    always_comb begin
        overflow_d = overflow_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r];
            if (claim_hit[r] && !load_hit[r]) begin
                if (pend_q[r] == PendMax) overflow_d = 1'b1;
                else                      pend_d[r]  = pend_q[r] + 1'b1;
            end else if (load_hit[r] && !claim_hit[r] && pend_q[r] != '0) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
            overflow_q <= overflow_d;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [SEL_W-1:0]      sel;
        logic [DATA_WIDTH-1:0] stored, operand;
        logic [PEND_W-1:0]     pend_sel;
        logic                  fwd_hit;

        assign sel = e_sel_q[p];

        always_comb begin
            stored   = '0;
            pend_sel = '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (sel == SEL_W'(r)) begin
                    stored   = regs_q[r];
                    pend_sel = pend_q[r];
                end
            end
        end

        // Lowest priority applied first so later assignments win.
        always_comb begin
            operand = stored;
            fwd_hit = 1'b0;
            if (wr_en && wr_sel == sel) operand = wr_val;
            for (int unsigned i = 0; i < NUM_FWD_STAGES; i++) begin
                if (!fwd_hit && fwd_valid[i] && fwd_sel[i*SEL_W +: SEL_W] == sel) begin
                    operand = fwd_val[i*DATA_WIDTH +: DATA_WIDTH];
                    fwd_hit = 1'b1;
                end
            end
            if (ZERO_REG && sel == '0) operand = '0;
        end

        assign rs_data[p*DATA_WIDTH +: DATA_WIDTH] = operand;

        // The last outstanding load completing this cycle is bypassed, so no stall.
        assign port_stall[p] = (pend_sel != '0) &&
                               !(wr_en && wr_is_load && wr_sel == sel && pend_sel == PEND_W'(1));
    end

    assign load_stall  = |port_stall;
    assign sb_overflow = overflow_q;

endmodule

// File: tb/tb_oldland_regbank.sv
// Scoreboard bench for oldland_regbank: expected outputs are queued as stimulus is driven and
// checked on the following falling edge.
module tb_oldland_regbank;
    localparam int SW = 3;
    localparam int KOp0 = 0, KOp1 = 1, KStall = 2, KOvf = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2*SW-1:0] rs_sel = '0;
    logic          hold = 1'b0;
    logic [63:0]   rs_data;
    logic [1:0]    fwd_valid = '0;
    logic [2*SW-1:0] fwd_sel = '0;
    logic [63:0]   fwd_val = '0;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [31:0]   wr_val = '0;
    logic          wr_is_load = 1'b0;
    logic          claim_en = 1'b0;
    logic [SW-1:0] claim_sel = '0;
    logic          load_stall, sb_overflow;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    oldland_regbank #(
        .DATA_WIDTH    (32),
        .NUM_REGS      (8),
        .NUM_READ_PORTS(2),
        .NUM_FWD_STAGES(2),
        .PEND_W        (2),
        .ZERO_REG      (1'b1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rs_sel     (rs_sel),
        .hold       (hold),
        .rs_data    (rs_data),
        .fwd_valid  (fwd_valid),
        .fwd_sel    (fwd_sel),
        .fwd_val    (fwd_val),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_val     (wr_val),
        .wr_is_load (wr_is_load),
        .claim_en   (claim_en),
        .claim_sel  (claim_sel),
        .load_stall (load_stall),
        .sb_overflow(sb_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            KOp0:    return rs_data[31:0];
            KOp1:    return rs_data[63:32];
            KStall:  return {31'b0, load_stall};
            default: return {31'b0, sb_overflow};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_eq(mon_e.tag, observe(mon_e.kind), mon_e.val);
        end
    end

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rs_sel     = '0;
        hold       = 1'b0;
        fwd_valid  = '0;
        fwd_sel    = '0;
        fwd_val    = '0;
        wr_en      = 1'b0;
        wr_is_load = 1'b0;
        claim_en   = 1'b0;
    endtask

    task automatic do_write(input logic [SW-1:0] sel, input logic [31:0] val, input logic load);
        wr_en      = 1'b1;
        wr_sel     = sel;
        wr_val     = val;
        wr_is_load = load;
    endtask

    task automatic do_claim(input logic [SW-1:0] sel);
        claim_en  = 1'b1;
        claim_sel = sel;
    endtask

    function automatic logic [2*SW-1:0] sels(input logic [SW-1:0] p0, input logic [SW-1:0] p1);
        return {p1, p0};
    endfunction

    initial begin
        #1;
        check_eq("reset_op0", rs_data[31:0], 32'h0);
        check_eq("reset_op1", rs_data[63:32], 32'h0);
        check_eq("reset_stall", {31'b0, load_stall}, 32'h0);
        check_eq("reset_ovf", {31'b0, sb_overflow}, 32'h0);
        #11 rst = 1'b0;

        // Write then read, write-through on the other port
        next_cycle(); do_write(3'd3, 32'hDEADBEEF, 1'b0);
        next_cycle(); rs_sel = sels(3'd3, 3'd6);
        next_cycle(); hold = 1'b1; do_write(3'd6, 32'hCAFEF00D, 1'b0);
        expect_out("rd_r3", KOp0, 32'hDEADBEEF);
        expect_out("wt_r6", KOp1, 32'hCAFEF00D);
        next_cycle(); hold = 1'b1;
        expect_out("hold_r3", KOp0, 32'hDEADBEEF);
        expect_out("stored_r6", KOp1, 32'hCAFEF00D);

        // Forwarding priority
        next_cycle(); rs_sel = sels(3'd2, 3'd7);
        next_cycle(); hold = 1'b1; fwd_valid = 2'b11; fwd_sel = {3'd2, 3'd2};
        fwd_val = {32'h22, 32'h11}; do_write(3'd2, 32'h33, 1'b0);
        expect_out("fwd_youngest", KOp0, 32'h11);
        expect_out("fwd_nomatch", KOp1, 32'h0);
        next_cycle(); hold = 1'b1; fwd_valid = 2'b10; fwd_sel = {3'd2, 3'd2};
        fwd_val = {32'h22, 32'h11}; do_write(3'd2, 32'h33, 1'b0);
        expect_out("fwd_stage1", KOp0, 32'h22);
        next_cycle(); hold = 1'b1; do_write(3'd2, 32'h33, 1'b0);
        expect_out("fwd_none_wt", KOp0, 32'h33);
        next_cycle(); hold = 1'b1; fwd_valid = 2'b01; fwd_sel = {3'd2, 3'd5};
        fwd_val = {32'h66, 32'h77};
        expect_out("fwd_invalid", KOp0, 32'h33);

        // Load stall and final-load bypass
        next_cycle(); rs_sel = sels(3'd5, 3'd7); do_claim(3'd5);
        next_cycle(); hold = 1'b1;
        expect_out("stall_r5", KStall, 32'h1);
        next_cycle(); hold = 1'b1;
        expect_out("stall_r5_held", KStall, 32'h1);
        next_cycle(); hold = 1'b1; do_write(3'd5, 32'h55, 1'b1);
        expect_out("bypass_stall", KStall, 32'h0);
        expect_out("bypass_op", KOp0, 32'h55);
        next_cycle(); hold = 1'b1;
        expect_out("after_load_stall", KStall, 32'h0);
        expect_out("after_load_op", KOp0, 32'h55);

        // Counter saturation
        next_cycle(); rs_sel = sels(3'd1, 3'd7); do_claim(3'd1);
        next_cycle(); hold = 1'b1; do_claim(3'd1);
        expect_out("sat_stall1", KStall, 32'h1);
        expect_out("sat_ovf0", KOvf, 32'h0);
        next_cycle(); hold = 1'b1; do_claim(3'd1);
        next_cycle(); hold = 1'b1; do_claim(3'd1);
        expect_out("sat_ovf_before4", KOvf, 32'h0);
        next_cycle(); hold = 1'b1; do_write(3'd1, 32'hA1, 1'b1);
        expect_out("sat_ovf_set", KOvf, 32'h1);
        expect_out("sat_pend3", KStall, 32'h1);
        next_cycle(); hold = 1'b1; do_write(3'd1, 32'hA2, 1'b1);
        expect_out("sat_pend2", KStall, 32'h1);
        next_cycle(); hold = 1'b1; do_write(3'd1, 32'hA3, 1'b1);
        expect_out("sat_pend1_bypass", KStall, 32'h0);
        expect_out("sat_op", KOp0, 32'hA3);
        next_cycle(); hold = 1'b1;
        expect_out("sat_clear", KStall, 32'h0);
        expect_out("sat_ovf_sticky", KOvf, 32'h1);

        // Simultaneous claim and load writeback, and non-load writeback
        next_cycle(); hold = 1'b1; do_claim(3'd1); do_write(3'd1, 32'hB0, 1'b1);
        expect_out("both_stall", KStall, 32'h0);
        expect_out("both_op", KOp0, 32'hB0);
        next_cycle(); hold = 1'b1;
        expect_out("both_nochange", KStall, 32'h0);
        next_cycle(); hold = 1'b1; do_claim(3'd1);
        next_cycle(); hold = 1'b1; do_write(3'd1, 32'hC0, 1'b0);
        expect_out("nonload_stall", KStall, 32'h1);
        expect_out("nonload_op", KOp0, 32'hC0);
        next_cycle(); hold = 1'b1;
        expect_out("nonload_kept", KStall, 32'h1);
        next_cycle(); hold = 1'b1; do_write(3'd1, 32'hC1, 1'b1);
        expect_out("nonload_final", KStall, 32'h0);

        // Zero register
        next_cycle(); rs_sel = sels(3'd0, 3'd0); do_write(3'd0, 32'hFFFF, 1'b0); do_claim(3'd0);
        next_cycle(); hold = 1'b1; fwd_valid = 2'b01; fwd_sel = {3'd0, 3'd0};
        fwd_val = {32'h0, 32'h99};
        expect_out("zero_op0", KOp0, 32'h0);
        expect_out("zero_op1", KOp1, 32'h0);
        expect_out("zero_stall", KStall, 32'h0);

        // Asynchronous reset mid-cycle
        next_cycle(); rs_sel = sels(3'd4, 3'd4); do_claim(3'd4); do_write(3'd4, 32'h1234, 1'b0);
        next_cycle(); hold = 1'b1; do_claim(3'd4);
        next_cycle(); hold = 1'b1;
        expect_out("prerst_stall", KStall, 32'h1);
        expect_out("prerst_op", KOp0, 32'h1234);
        #6 rst = 1'b1;
        #1;
        check_eq("rst_op0", rs_data[31:0], 32'h0);
        check_eq("rst_op1", rs_data[63:32], 32'h0);
        check_eq("rst_stall", {31'b0, load_stall}, 32'h0);
        check_eq("rst_ovf", {31'b0, sb_overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle(); rs_sel = sels(3'd4, 3'd4);
        next_cycle(); hold = 1'b1;
        expect_out("postrst_op", KOp0, 32'h0);
        expect_out("postrst_stall", KStall, 32'h0);
        next_cycle(); hold = 1'b1; do_write(3'd4, 32'h777, 1'b1);
        expect_out("stale_load_stall", KStall, 32'h0);
        expect_out("stale_load_op", KOp0, 32'h777);
        next_cycle(); hold = 1'b1; do_claim(3'd4);
        expect_out("no_underflow", KStall, 32'h0);
        next_cycle(); hold = 1'b1;
        expect_out("claim_after_rst", KStall, 32'h1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
